param_seq_detector: RTL and testbench

- Parametrised successor to the fixed 3-bit "111" Mealy detector.
- Serial bit stream with qualifying valid; detects an arbitrary PATTERN of SEQ_LEN bits; first bit in time = MSB of PATTERN.
- Overlapping or non-overlapping detection selected by parameter.
- Saturating match counter for status readback; used wherever the design needs a serial-pattern trigger.

---
 rtl/param_seq_detector_pkg.sv | 18 +
 rtl/sat_counter.sv | 22 ++
 rtl/param_seq_detector.sv | 93 +++++++++
 tb/tb_param_seq_detector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/param_seq_detector_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   SEQ_LEN_MAX  : widest supported pattern
//   seq_t        : container type for patterns and history windows
//   mask_pattern : keeps the low len bits of a pattern, zeroing the rest
package param_seq_detector_pkg;

   localparam int unsigned SEQ_LEN_MAX = 32;

   typedef logic [SEQ_LEN_MAX-1:0] seq_t;

   function automatic seq_t mask_pattern(input seq_t pat, input int unsigned len);
      seq_t m;
      if (len >= SEQ_LEN_MAX) m = '1;
      else                    m = (seq_t'(1) << len) - seq_t'(1);
      return pat & m;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear, wins over inc
//   inc          : count up by one, holds at all-ones
//   q            : current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                       q <= '0;
      else if (clr)                       q <= '0;
      else if (inc && (q != {W{1'b1}}))   q <= q + W'(1);
   end

endmodule

// File: rtl/param_seq_detector.sv
// Serial pattern detector. Bits arrive on x qualified by in_valid; the first
// bit in time lands in the MSB of the comparison window. Matches raise z and
// bump a saturating match counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   x, in_valid  : serial data and its qualifier
//   count_clr    : synchronous clear of match_count
//   z            : match flag (combinational Mealy by default)
//   match_count  : saturating number of matches
// Build option: define PARAM_SEQ_DETECTOR_MOORE_OUT_EN to register z
// (one cycle later, glitch-free); match_count timing is unchanged.
//
// fill is the state:
//   fill        | meaning
//   0           | no valid bits held
//   1..SEQ_LEN-2| that many valid bits held, window not yet full
//   SEQ_LEN-1   | history primed, compare is live on every valid bit
module param_seq_detector
   import param_seq_detector_pkg::*;
#(
   parameter int   SEQ_LEN = 3,
   parameter seq_t PATTERN = 3'b111,
   parameter bit   OVERLAP = 1'b1,
   parameter int   CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             x,
   input  logic             in_valid,
   input  logic             count_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_count
);

   localparam int   HIST_W    = SEQ_LEN - 1;
   localparam int   FILL_W    = $clog2(SEQ_LEN);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);
   localparam seq_t PAT_M     = mask_pattern(PATTERN, SEQ_LEN);

   logic [HIST_W-1:0]  hist, hist_nxt;
   logic [FILL_W-1:0]  fill, fill_nxt;
   logic [SEQ_LEN-1:0] window;
   logic               match_term;

   assign window     = {hist, x};
   assign match_term = in_valid && (fill == FILL_LAST) && (seq_t'(window) == PAT_M);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist <= '0;
         fill <= '0;
      end else begin
         hist <= hist_nxt;
         fill <= fill_nxt;
      end
   end

   always_comb begin
      hist_nxt = hist;
      fill_nxt = fill;
      if (in_valid) begin
         if (match_term && !OVERLAP) begin
            // non-overlapping: the next match must be built from fresh bits
            hist_nxt = '0;
            fill_nxt = '0;
         end else begin
            hist_nxt = (hist << 1) | HIST_W'(x);
            if (fill != FILL_LAST) fill_nxt = fill + FILL_W'(1);
         end
      end
   end

`ifdef PARAM_SEQ_DETECTOR_MOORE_OUT_EN
   logic z_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) z_q <= 1'b0;
      else          z_q <= match_term;
   end

   assign z = z_q;
`else
   assign z = match_term;
`endif

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (count_clr),
      .inc     (match_term),
      .q       (match_count)
   );

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

   logic clk = 1'b1;
   logic reset_n;
   logic x, in_valid, count_clr;

   logic       z0, z1, z2, z3, z4;
   logic [7:0] c0, c1, c2, c3;
   logic [1:0] c4;

   int         sel;
   logic       z_o;
   logic [31:0] c_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic prev_ez = 1'b0;

   always #5 clk = ~clk;

   // d0: defaults (111, overlap)
   param_seq_detector d0 (.clk(clk), .reset_n(reset_n), .x(x), .in_valid(in_valid),
                          .count_clr(count_clr), .z(z0), .match_count(c0));
   // d1: 111, non-overlapping
   param_seq_detector #(.OVERLAP(1'b0)) d1 (.clk(clk), .reset_n(reset_n), .x(x),
                          .in_valid(in_valid), .count_clr(count_clr), .z(z1), .match_count(c1));
   // d2: 1011, overlap
   param_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b1011)) d2 (.clk(clk), .reset_n(reset_n),
                          .x(x), .in_valid(in_valid), .count_clr(count_clr), .z(z2), .match_count(c2));
   // d3: 1011, non-overlapping
   param_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) d3 (.clk(clk),
                          .reset_n(reset_n), .x(x), .in_valid(in_valid), .count_clr(count_clr),
                          .z(z3), .match_count(c3));
   // d4: 2-bit counter
   param_seq_detector #(.CNT_W(2)) d4 (.clk(clk), .reset_n(reset_n), .x(x), .in_valid(in_valid),
                          .count_clr(count_clr), .z(z4), .match_count(c4));

   always_comb begin
      z_o = 1'b0;
      c_o = '0;
      case (sel)
         0: begin z_o = z0; c_o = 32'(c0); end
         1: begin z_o = z1; c_o = 32'(c1); end
         2: begin z_o = z2; c_o = 32'(c2); end
         3: begin z_o = z3; c_o = 32'(c3); end
         4: begin z_o = z4; c_o = 32'(c4); end
         default: begin z_o = 1'b0; c_o = '0; end
      endcase
   end

   task automatic chk_z(input logic exp, input string tag);
      n_tests++;
      assert (z_o === exp) else begin
         n_fail++;
         $error("FAIL %s: z observed %b expected %b", tag, z_o, exp);
      end
   endtask

   task automatic chk_cnt(input logic [31:0] exp, input string tag);
      n_tests++;
      assert (c_o === exp) else begin
         n_fail++;
         $error("FAIL %s: match_count observed %0d expected %0d", tag, c_o, exp);
      end
   endtask

   // ez is the combinational match term for this cycle; with the registered
   // output option, z shows the previous cycle's term instead.
   task automatic step(input logic xv, input logic vv, input logic ez, input logic cv,
                       input string tag);
      logic exp;
      @(negedge clk);
      x = xv; in_valid = vv; count_clr = cv;
      #1;
`ifdef PARAM_SEQ_DETECTOR_MOORE_OUT_EN
      exp = prev_ez;
`else
      exp = ez;
`endif
      chk_z(exp, tag);
      prev_ez = ez;
      @(posedge clk);
      #1;
      in_valid = 1'b0; count_clr = 1'b0; x = 1'b0;
   endtask

   // bits[n-1] is the first bit in time; zexp likewise
   task automatic run_stream(input logic [31:0] bits, input logic [31:0] zexp, input int n,
                             input string tag);
      for (int i = 0; i < n; i++)
         step(bits[n-1-i], 1'b1, zexp[n-1-i], 1'b0, tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset_n = 1'b0;
      #2 reset_n = 1'b1;
      prev_ez = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; x = 1'b0; in_valid = 1'b0; count_clr = 1'b0; sel = 0;
      #12;
      chk_z(1'b0, "reset_z");
      chk_cnt(0, "reset_cnt");
      #3 reset_n = 1'b1;

      // defaults: no three consecutive ones, then a run of four
      sel = 0;
      run_stream(32'b0010_1101_1001_0110, 32'h0, 16, "def_noise");
      chk_cnt(0, "def_noise_cnt");
      run_stream(32'b1111, 32'b0011, 4, "def_ones");
      chk_cnt(2, "def_ones_cnt");

      // non-overlapping 111
      do_reset(); sel = 1;
      run_stream(32'b111111, 32'b001001, 6, "novl_111");
      chk_cnt(2, "novl_111_cnt");

      // 1011 overlapping
      do_reset(); sel = 2;
      run_stream(32'b1011011, 32'b0001001, 7, "ovl_1011");
      chk_cnt(2, "ovl_1011_cnt");

      // 1011 non-overlapping
      do_reset(); sel = 3;
      run_stream(32'b1011011, 32'b0001000, 7, "novl_1011");
      chk_cnt(1, "novl_1011_cnt");

      // in_valid gaps do not break a partial match
      do_reset(); sel = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, "gap_v1");
      step(1'b0, 1'b0, 1'b0, 1'b0, "gap_i1");
      step(1'b1, 1'b1, 1'b0, 1'b0, "gap_v2");
      step(1'b0, 1'b0, 1'b0, 1'b0, "gap_i2");
      step(1'b1, 1'b1, 1'b1, 1'b0, "gap_v3");
      step(1'b1, 1'b0, 1'b0, 1'b0, "gap_inv_x1");
      chk_cnt(1, "gap_cnt");

      // saturation at 2 bits, then clear beating a match
      do_reset(); sel = 4;
      run_stream(32'b11, 32'b00, 2, "sat_pre");
      chk_cnt(0, "sat_c0");
      step(1'b1, 1'b1, 1'b1, 1'b0, "sat_m1"); chk_cnt(1, "sat_c1");
      step(1'b1, 1'b1, 1'b1, 1'b0, "sat_m2"); chk_cnt(2, "sat_c2");
      step(1'b1, 1'b1, 1'b1, 1'b0, "sat_m3"); chk_cnt(3, "sat_c3");
      step(1'b1, 1'b1, 1'b1, 1'b0, "sat_m4"); chk_cnt(3, "sat_hold");
      step(1'b1, 1'b1, 1'b1, 1'b1, "clr_m");  chk_cnt(0, "clr_wins");
      step(1'b1, 1'b1, 1'b1, 1'b0, "post_clr"); chk_cnt(1, "post_clr_cnt");

      // asynchronous reset mid-stream
      do_reset(); sel = 0;
      run_stream(32'b111, 32'b001, 3, "ar_pre");
      run_stream(32'b011, 32'b000, 3, "ar_two");
      chk_cnt(1, "ar_pre_cnt");
      @(negedge clk);
      x = 1'b1; in_valid = 1'b1;
      #1;
`ifdef PARAM_SEQ_DETECTOR_MOORE_OUT_EN
      chk_z(1'b0, "ar_live");
`else
      chk_z(1'b1, "ar_live");
`endif
      reset_n = 1'b0;
      #1;
      chk_z(1'b0, "ar_z_now");
      chk_cnt(0, "ar_cnt_now");
      in_valid = 1'b0; x = 1'b0;
      #1 reset_n = 1'b1;
      prev_ez = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0, "ar_single");
      run_stream(32'b11, 32'b01, 2, "ar_full");
      step(1'b0, 1'b0, 1'b0, 1'b0, "ar_tail");
      chk_cnt(1, "ar_full_cnt");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
